// File: rtl/lii_out_rr_arbiter.sv
// lii_out_rr_arbiter
//   Shares one LII phy output channel between N kernel-wrapper output streams.
//   A round-robin arbiter grants one requester at a time and locks onto it for
//   up to MAX_BURST accepted beats. Accepted beats go into a single registered
//   output stage that drives the phy at one beat per cycle.
//
// Ports
//   aclk            clock, rising edge
//   arst            synchronous reset, active-high
//   req_tdata       requester beats, requester i at [i*PW +: PW]
//   req_tvalid      per-requester beat valid
//   req_tready      per-requester accept (only the granted one can be high)
//   req_src/dst     per-requester 8-bit tags, [i*8 +: 8]
//   lii_out_tdata   registered phy output beat
//   lii_out_tvalid  registered phy output valid
//   lii_out_tready  phy ready
//   lii_out_src/dst tags travelling with the current output beat
//   grant_id        granted requester index (meaningful while busy=1)
//   busy            high while locked onto a requester
module lii_out_rr_arbiter #(
    parameter int unsigned N         = 4,
    parameter int unsigned PW        = 128,
    parameter int unsigned MAX_BURST = 16,
    localparam int unsigned IW       = (N > 1) ? $clog2(N) : 1
) (
    input  logic            aclk,
    input  logic            arst,
    input  logic [N*PW-1:0] req_tdata,
    input  logic [N-1:0]    req_tvalid,
    output logic [N-1:0]    req_tready,
    input  logic [N*8-1:0]  req_src,
    input  logic [N*8-1:0]  req_dst,
    output logic [PW-1:0]   lii_out_tdata,
    output logic            lii_out_tvalid,
    input  logic            lii_out_tready,
    output logic [7:0]      lii_out_src,
    output logic [7:0]      lii_out_dst,
    output logic [IW-1:0]   grant_id,
    output logic            busy
);

    localparam int unsigned CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    typedef enum logic [0:0] {StIdle, StLock} state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]   grant_q, grant_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            out_valid_q, out_valid_d;
    logic [PW-1:0]   out_data_q, out_data_d;
    logic [7:0]      out_src_q, out_src_d;
    logic [7:0]      out_dst_q, out_dst_d;

    logic            load_en;
    logic            accept;
    logic            burst_last;
    logic [IW-1:0]   ptr_after_grant;
    logic [IW-1:0]   pick_idx;
    logic            pick_found;
    logic [IW:0]     scan;

    // Output register can take a new beat when empty or draining this cycle.
    assign load_en    = !out_valid_q || lii_out_tready;
    assign accept     = (state_q == StLock) && req_tvalid[grant_q] && load_en;
    assign burst_last = (cnt_q == CW'(MAX_BURST - 1));
    assign ptr_after_grant = (grant_q == IW'(N - 1)) ? '0 : grant_q + IW'(1);

    // Round-robin scan starting at rr_ptr, wrapping modulo N.
    always_comb begin
        pick_idx   = '0;
        pick_found = 1'b0;
        scan       = '0;
        for (int unsigned k = 0; k < N; k++) begin
            scan = {1'b0, rr_ptr_q} + (IW + 1)'(k);
            if (scan >= (IW + 1)'(N)) begin
                scan = scan - (IW + 1)'(N);
            end
            if (!pick_found && req_tvalid[scan[IW-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = scan[IW-1:0];
            end
        end
    end

    always_comb begin
        req_tready = '0;
        if (state_q == StLock) begin
            req_tready[grant_q] = load_en;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        out_dst_d   = out_dst_q;

        unique case (state_q)
            StIdle: begin
                if (|req_tvalid) begin
                    state_d = StLock;
                    grant_d = pick_idx;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            StLock: begin
                if (accept) begin
                    cnt_d = cnt_q + CW'(1);
                end
                // Leave on a full burst, or as soon as the owner has nothing
                // to offer while the output stage could have taken a beat.
                if ((accept && burst_last) || (load_en && !req_tvalid[grant_q])) begin
                    state_d  = StIdle;
                    busy_d   = 1'b0;
                    rr_ptr_d = ptr_after_grant;
                end
            end
            default: state_d = StIdle;
        endcase

        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = req_tdata[grant_q*PW +: PW];
            out_src_d   = req_src[grant_q*8 +: 8];
            out_dst_d   = req_dst[grant_q*8 +: 8];
        end else if (lii_out_tready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (arst) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            out_dst_q   <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            out_dst_q   <= out_dst_d;
        end
    end

    assign lii_out_tdata  = out_data_q;
    assign lii_out_tvalid = out_valid_q;
    assign lii_out_src    = out_src_q;
    assign lii_out_dst    = out_dst_q;
    assign grant_id       = grant_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_lii_out_rr_arbiter.sv
// Bench for lii_out_rr_arbiter: randomized requester streams, a transaction
// level arbiter model and a per-requester scoreboard; a second instance with
// MAX_BURST=1 checks single-beat alternation.
module tb_lii_out_rr_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned PW = 128;
    localparam int unsigned MB = 4;
    localparam int unsigned IW = 2;

    logic aclk = 1'b0;
    always #5 aclk = ~aclk;

    logic            arst;
    logic [N*PW-1:0] req_tdata;
    logic [N-1:0]    req_tvalid;
    logic [N-1:0]    req_tready;
    logic [N*8-1:0]  req_src;
    logic [N*8-1:0]  req_dst;
    logic [PW-1:0]   lii_out_tdata;
    logic            lii_out_tvalid;
    logic            lii_out_tready;
    logic [7:0]      lii_out_src;
    logic [7:0]      lii_out_dst;
    logic [IW-1:0]   grant_id;
    logic            busy;

    lii_out_rr_arbiter #(.N(N), .PW(PW), .MAX_BURST(MB)) u_dut (
        .aclk           (aclk),
        .arst           (arst),
        .req_tdata      (req_tdata),
        .req_tvalid     (req_tvalid),
        .req_tready     (req_tready),
        .req_src        (req_src),
        .req_dst        (req_dst),
        .lii_out_tdata  (lii_out_tdata),
        .lii_out_tvalid (lii_out_tvalid),
        .lii_out_tready (lii_out_tready),
        .lii_out_src    (lii_out_src),
        .lii_out_dst    (lii_out_dst),
        .grant_id       (grant_id),
        .busy           (busy)
    );

    // Second instance: N=2, MAX_BURST=1.
    logic        arst2;
    logic [31:0] tdata2;
    logic [1:0]  tvalid2;
    logic [1:0]  tready2;
    logic [15:0] src2;
    logic [15:0] dst2;
    logic [15:0] out_data2;
    logic        out_valid2;
    logic        out_ready2;
    logic [7:0]  out_src2;
    logic [7:0]  out_dst2;
    logic [0:0]  grant2;
    logic        busy2;

    lii_out_rr_arbiter #(.N(2), .PW(16), .MAX_BURST(1)) u_mb1 (
        .aclk           (aclk),
        .arst           (arst2),
        .req_tdata      (tdata2),
        .req_tvalid     (tvalid2),
        .req_tready     (tready2),
        .req_src        (src2),
        .req_dst        (dst2),
        .lii_out_tdata  (out_data2),
        .lii_out_tvalid (out_valid2),
        .lii_out_tready (out_ready2),
        .lii_out_src    (out_src2),
        .lii_out_dst    (out_dst2),
        .grant_id       (grant2),
        .busy           (busy2)
    );

    typedef struct packed {
        logic [PW-1:0] data;
        logic [7:0]    dst;
    } beat_t;

    beat_t stim_q[N][$];
    beat_t exp_q[N][$];
    int    grant_log[$];
    int    burst_log[$];

    int          n_checks = 0;
    int          n_pass   = 0;
    int unsigned en_prob[N];
    int unsigned rdy_prob;
    bit          force_stall;
    bit          mb1_done = 1'b0;

    function automatic logic [7:0] src_of(int i);
        return 8'hA0 + 8'(i);
    endfunction

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    task automatic check_seq(input string name, input int got[$], input int want[$]);
        check({name, "_len"}, 160'(got.size()), 160'(want.size()));
        for (int k = 0; k < want.size(); k++) begin
            if (k < got.size()) check($sformatf("%s_%0d", name, k), 160'(got[k]), 160'(want[k]));
        end
    endtask

    function automatic int pick(int ptr, logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return 0;
    endfunction

    function automatic bit all_empty();
        for (int i = 0; i < N; i++) begin
            if (stim_q[i].size() != 0 || exp_q[i].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic add_beats(int i, int n);
        beat_t b;
        for (int k = 0; k < n; k++) begin
            b.data = {$urandom, $urandom, $urandom, $urandom};
            b.dst  = 8'($urandom);
            stim_q[i].push_back(b);
            exp_q[i].push_back(b);
        end
    endtask

    // One clock of requester/phy driving; inputs change 1 time unit after the edge.
    task automatic step();
        logic [N-1:0] hs;
        @(negedge aclk);
        hs = req_tvalid & req_tready;
        @(posedge aclk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (hs[i] && stim_q[i].size() > 0) stim_q[i].delete(0);
            if (stim_q[i].size() > 0 && $urandom_range(99) < en_prob[i]) begin
                req_tvalid[i]          = 1'b1;
                req_tdata[i*PW +: PW]  = stim_q[i][0].data;
                req_dst[i*8 +: 8]      = stim_q[i][0].dst;
            end else begin
                req_tvalid[i] = 1'b0;
            end
        end
        lii_out_tready = !force_stall && ($urandom_range(99) < rdy_prob);
    endtask

    task automatic do_reset();
        arst       = 1'b1;
        req_tvalid = '0;
        for (int i = 0; i < N; i++) begin
            stim_q[i].delete();
            exp_q[i].delete();
        end
        step();
        arst = 1'b0;
        grant_log.delete();
        burst_log.delete();
    endtask

    task automatic drain(input string name, input int limit);
        int k = 0;
        while (!all_empty() && k < limit) begin
            step();
            k++;
        end
        repeat (3) step();
        check({name, "_drained"}, 160'(all_empty()), 160'(1));
    endtask

    // Reference model state
    bit            mon_on = 1'b0;
    bit            rst_chk = 1'b0;
    bit            m_busy;
    int            m_grant;
    int            m_ptr;
    int            m_cnt;
    bit            m_ov;
    logic [PW-1:0] m_od;
    logic [7:0]    m_osrc;
    logic [7:0]    m_odst;
    bit            m_load;
    bit            m_acc;
    bit            m_end;
    logic [N-1:0]  m_rdy;
    int            m_idx;
    beat_t         m_b;

    always @(negedge aclk) begin
        if (rst_chk) begin
            check("rst_tvalid", 160'(lii_out_tvalid), 160'(0));
            check("rst_busy", 160'(busy), 160'(0));
            check("rst_grant", 160'(grant_id), 160'(0));
            check("rst_req_tready", 160'(req_tready), 160'(0));
            check("rst_out_regs", {lii_out_src, lii_out_dst, lii_out_tdata}, 160'(0));
            rst_chk = 1'b0;
        end
        if (arst) begin
            rst_chk = 1'b1;
            mon_on  = 1'b1;
            m_busy  = 1'b0;
            m_grant = 0;
            m_ptr   = 0;
            m_cnt   = 0;
            m_ov    = 1'b0;
        end else if (mon_on) begin
            m_load = !m_ov || lii_out_tready;
            check("busy", 160'(busy), 160'(m_busy));
            if (m_busy) check("grant_id", 160'(grant_id), 160'(m_grant));
            m_rdy = '0;
            if (m_busy) m_rdy[m_grant] = m_load;
            check("req_tready", 160'(req_tready), 160'(m_rdy));
            check("out_valid", 160'(lii_out_tvalid), 160'(m_ov));
            if (m_ov) begin
                check("out_reg", {lii_out_src, lii_out_dst, lii_out_tdata},
                      {m_osrc, m_odst, m_od});
            end
            // End-to-end scoreboard, keyed by the source tag.
            if (lii_out_tvalid && lii_out_tready) begin
                m_idx = int'(lii_out_src) - 'hA0;
                if (m_idx < 0 || m_idx >= N || exp_q[m_idx].size() == 0) begin
                    n_checks++;
                    $display("FAIL out_unexpected: got beat with src %0h, required none", lii_out_src);
                end else begin
                    m_b = exp_q[m_idx].pop_front();
                    check("out_beat", {lii_out_dst, lii_out_tdata}, {m_b.dst, m_b.data});
                end
            end
            // Advance the model by one clock.
            m_acc = m_busy && req_tvalid[m_grant] && m_load;
            if (m_acc) begin
                m_ov   = 1'b1;
                m_od   = req_tdata[m_grant*PW +: PW];
                m_osrc = req_src[m_grant*8 +: 8];
                m_odst = req_dst[m_grant*8 +: 8];
            end else if (lii_out_tready) begin
                m_ov = 1'b0;
            end
            m_end = 1'b0;
            if (!m_busy) begin
                if (|req_tvalid) begin
                    m_grant = pick(m_ptr, req_tvalid);
                    m_busy  = 1'b1;
                    m_cnt   = 0;
                    grant_log.push_back(m_grant);
                end
            end else if (m_acc) begin
                m_cnt++;
                if (m_cnt == MB) m_end = 1'b1;
            end else if (m_load && !req_tvalid[m_grant]) begin
                m_end = 1'b1;
            end
            if (m_end) begin
                m_busy = 1'b0;
                m_ptr  = (m_grant + 1) % N;
                burst_log.push_back(m_cnt);
            end
        end
    end

    // MAX_BURST=1 instance: both requesters always valid, phy always ready.
    initial begin
        int exp_g;
        int exp_s;
        int ng;
        arst2      = 1'b1;
        tvalid2    = 2'b11;
        tdata2     = 32'h2222_1111;
        src2       = 16'hB1B0;
        dst2       = 16'hC1C0;
        out_ready2 = 1'b1;
        repeat (2) @(posedge aclk);
        #1 arst2 = 1'b0;
        exp_g = 0;
        exp_s = 0;
        ng    = 0;
        for (int c = 0; c < 24; c++) begin
            @(negedge aclk);
            if (busy2) begin
                check("mb1_grant", 160'(grant2), 160'(exp_g));
                exp_g ^= 1;
                ng++;
            end
            if (out_valid2) begin
                check("mb1_out", {out_src2, out_dst2, out_data2},
                      {8'hB0 + 8'(exp_s), 8'hC0 + 8'(exp_s), exp_s ? 16'h2222 : 16'h1111});
                exp_s ^= 1;
            end
        end
        check("mb1_grant_count", 160'(ng >= 10), 160'(1));
        mb1_done = 1'b1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        int w[$];
        int k;
        arst           = 1'b1;
        req_tvalid     = '0;
        req_tdata      = '0;
        req_dst        = '0;
        lii_out_tready = 1'b0;
        force_stall    = 1'b0;
        rdy_prob       = 100;
        for (int i = 0; i < N; i++) begin
            req_src[i*8 +: 8] = src_of(i);
            en_prob[i]        = 100;
        end
        step();
        step();
        arst = 1'b0;
        grant_log.delete();
        burst_log.delete();

        // Only req2 with 6 beats: burst of 4, one idle cycle, re-grant for 2.
        add_beats(2, 6);
        drain("p1", 200);
        w = {2, 2};
        check_seq("p1_grants", grant_log, w);
        w = {4, 2};
        check_seq("p1_bursts", burst_log, w);

        // All four continuously valid: strict rotation, full bursts.
        do_reset();
        for (int i = 0; i < N; i++) add_beats(i, 8);
        drain("p2", 300);
        w = {0, 1, 2, 3, 0, 1, 2, 3};
        check_seq("p2_grants", grant_log, w);
        w = {4, 4, 4, 4, 4, 4, 4, 4};
        check_seq("p2_bursts", burst_log, w);

        // Phy stall of 5 cycles mid-burst.
        do_reset();
        for (int i = 0; i < N; i++) add_beats(i, 8);
        repeat (6) step();
        force_stall = 1'b1;
        repeat (5) step();
        force_stall = 1'b0;
        drain("p3", 300);

        // req1 runs dry after 2 beats while req3 waits.
        do_reset();
        add_beats(1, 2);
        add_beats(3, 3);
        drain("p4", 200);
        w = {1, 3};
        check_seq("p4_grants", grant_log, w);
        w = {2, 3};
        check_seq("p4_bursts", burst_log, w);

        // Reset while locked with a beat held in the output register.
        do_reset();
        for (int i = 0; i < N; i++) add_beats(i, 8);
        k = 0;
        while (!(busy && lii_out_tvalid) && k < 20) begin
            step();
            k++;
        end
        check("p5_locked_before_reset", 160'(busy && lii_out_tvalid), 160'(1));
        do_reset();
        for (int i = 0; i < N; i++) add_beats(i, 4);
        drain("p5", 300);
        w = {0, 1, 2, 3};
        check_seq("p5_grants", grant_log, w);

        // Randomized traffic and backpressure.
        do_reset();
        for (int i = 0; i < N; i++) begin
            add_beats(i, 25);
            en_prob[i] = $urandom_range(90, 30);
        end
        rdy_prob = 60;
        repeat (300) step();
        for (int i = 0; i < N; i++) en_prob[i] = 100;
        rdy_prob = 100;
        drain("p6", 600);

        k = 0;
        while (!mb1_done && k < 100) begin
            step();
            k++;
        end
        check("mb1_finished", 160'(mb1_done), 160'(1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
